// File: rtl/toggle_period_meter.sv
// Measures sys_clk cycles between successive edges of an asynchronous toggling input.
// Optional in-range check of each interval is enabled by defining PERIOD_CHECK_EN.
module toggle_period_meter #(
  parameter int               CNT_W       = 25,
  parameter logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(29_999_999),
  parameter logic [CNT_W-1:0] EXP_CNT     = CNT_W'(25_000_000),
  parameter logic [CNT_W-1:0] TOL         = CNT_W'(1_000)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_vld,
  output logic             timeout,
  output logic [7:0]       edge_cnt
`ifdef PERIOD_CHECK_EN
  ,
  output logic             period_ok
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, LOST} state_t;

  state_t           state, state_nxt;
  logic             sig_s1, sig_s2, sig_d;
  logic             sig_edge;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic             vld_nxt;
  logic             timeout_nxt;
  logic             cnt_at_limit;

  // Two-flop synchronizer plus one delay stage for edge detection of either polarity.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sig_s1 <= 1'b0;
      sig_s2 <= 1'b0;
      sig_d  <= 1'b0;
    end else begin
      sig_s1 <= sig_in;
      sig_s2 <= sig_s1;
      sig_d  <= sig_s2;
    end
  end

  assign sig_edge     = sig_s2 ^ sig_d;
  assign cnt_at_limit = (cnt == TIMEOUT_MAX - CNT_W'(1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      period_out <= '0;
      period_vld <= 1'b0;
      timeout    <= 1'b0;
      edge_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      period_out <= period_nxt;
      period_vld <= vld_nxt;
      timeout    <= timeout_nxt;
      edge_cnt   <= edge_cnt + {7'd0, sig_edge};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sig_edge) state_nxt = RUN;
      RUN:     if (!sig_edge && cnt_at_limit) state_nxt = LOST;
      LOST:    if (sig_edge) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // An edge coinciding with the last counting cycle still reports a valid interval.
  always_comb begin
    cnt_nxt     = '0;
    period_nxt  = period_out;
    vld_nxt     = 1'b0;
    timeout_nxt = timeout;
    case (state)
      RUN: begin
        if (sig_edge) begin
          period_nxt = cnt + CNT_W'(1);
          vld_nxt    = 1'b1;
        end else if (cnt_at_limit) begin
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      LOST:    if (sig_edge) timeout_nxt = 1'b0;
      default: ;
    endcase
  end

`ifdef PERIOD_CHECK_EN
  logic [CNT_W:0] meas_w;
  logic           meas_in_range;

  // Bounds compared one bit wider so EXP_CNT-TOL and EXP_CNT+TOL cannot wrap.
  assign meas_w        = {1'b0, cnt} + (CNT_W+1)'(1);
  assign meas_in_range = (meas_w + {1'b0, TOL} >= {1'b0, EXP_CNT}) &&
                         (meas_w <= {1'b0, EXP_CNT} + {1'b0, TOL});

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      period_ok <= 1'b0;
    end else if (state == RUN) begin
      if (sig_edge) period_ok <= meas_in_range;
      else if (cnt_at_limit) period_ok <= 1'b0;
    end
  end
`else
  logic unused_check_params;
  assign unused_check_params = ^{EXP_CNT, TOL};
`endif

endmodule
